// File: rtl/car_ctrl_pkg.sv
// Shared types and helpers for the car power / drive-mode controller.
package car_ctrl_pkg;

  localparam int unsigned STATE_W   = 2;
  localparam int unsigned MAX_MODES = 32;

  typedef enum logic [STATE_W-1:0] {
    PWR_OFF    = 2'd0,
    PWR_ARMING = 2'd1,
    PWR_ON     = 2'd2
  } pwr_state_e;

  // True when exactly one bit of v is set; narrower vectors are zero-extended by the caller.
  function automatic logic onehot_ok(input logic [MAX_MODES-1:0] v);
    int unsigned ones;
    ones = 0;
    for (int i = 0; i < MAX_MODES; i++) begin
      ones = ones + 32'(v[i]);
    end
    return (ones == 32'd1);
  endfunction

endpackage

// File: rtl/power_mode_ctrl_btn_filter.sv
// Two-flop synchroniser followed by a tick-sampled debounce filter for one raw input.
module btn_filter #(
  parameter int unsigned DEB_TICKS = 2
) (
  input  logic sys_clk,
  input  logic rst_n,
  input  logic tick,
  input  logic din,
  output logic dout
);

  localparam int unsigned CNT_W = $clog2(DEB_TICKS + 1);

  logic [1:0]       sync_q;
  logic             dout_q, dout_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Output only flips after DEB_TICKS consecutive disagreeing ticks.
  always_comb begin
    dout_d = dout_q;
    cnt_d  = cnt_q;
    if (tick) begin
      if (sync_q[1] != dout_q) begin
        if (cnt_q == CNT_W'(DEB_TICKS - 1)) begin
          dout_d = sync_q[1];
          cnt_d  = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end else begin
        cnt_d = '0;
      end
    end
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      dout_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      sync_q <= {sync_q[0], din};
      dout_q <= dout_d;
      cnt_q  <= cnt_d;
    end
  end

  assign dout = dout_q;

endmodule

// File: rtl/power_mode_ctrl.sv
// Power and drive-mode controller: debounced buttons, hold-to-start FSM and
// one-hot validated mode enables, all clocked by sys_clk with a sampling tick.
module power_mode_ctrl
  import car_ctrl_pkg::*;
#(
  parameter int unsigned CLK_HZ        = 100_000_000,
  parameter int unsigned TICK_HZ       = 100,
  parameter int unsigned DEB_TICKS     = 2,
  parameter int unsigned ON_HOLD_TICKS = 100,
  parameter int unsigned N_MODES       = 3
) (
  input  logic               sys_clk,
  input  logic               rst_n,
  input  logic               power_on_btn,
  input  logic               power_off_btn,
  input  logic [N_MODES-1:0] mode_sw,
  output logic               power_led,
  output logic [N_MODES-1:0] mode_en,
  output logic [N_MODES-1:0] mode_led,
  output logic               power_up_pulse,
  output logic [1:0]         state
);

  localparam int unsigned DIV          = CLK_HZ / TICK_HZ;
  localparam int unsigned TICK_W       = $clog2(DIV);
  localparam int unsigned HOLD_W       = $clog2(ON_HOLD_TICKS + 1);
  localparam int unsigned SETTLE_TICKS = DEB_TICKS + 1;
  localparam int unsigned SETTLE_W     = $clog2(SETTLE_TICKS + 1);
  localparam int unsigned NF           = N_MODES + 2;

  logic [TICK_W-1:0]   tick_cnt_q, tick_cnt_d;
  logic                tick_c;
  logic [NF-1:0]       raw_c, filt_c;
  logic                on_f, off_f;
  logic [N_MODES-1:0]  mode_f;

  logic [SETTLE_W-1:0] settle_q, settle_d;
  logic                settled_c;
  logic                on_prev_q, on_prev_d;
  logic                on_rise_c;

  pwr_state_e          state_q, state_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic                pulse_q, pulse_d;
  logic                led_q, led_d;
  logic [N_MODES-1:0]  mode_q, mode_d;

  // Clock-enable tick at the wrap of the divider counter.
  assign tick_c     = (tick_cnt_q == TICK_W'(DIV - 1));
  assign tick_cnt_d = tick_c ? '0 : tick_cnt_q + TICK_W'(1);

  assign raw_c = {mode_sw, power_off_btn, power_on_btn};

  for (genvar g = 0; g < NF; g++) begin : g_filt
    btn_filter #(
      .DEB_TICKS (DEB_TICKS)
    ) u_filt (
      .sys_clk (sys_clk),
      .rst_n   (rst_n),
      .tick    (tick_c),
      .din     (raw_c[g]),
      .dout    (filt_c[g])
    );
  end

  assign on_f   = filt_c[0];
  assign off_f  = filt_c[1];
  assign mode_f = filt_c[NF-1:2];

  // After reset the filters need DEB_TICKS+1 ticks to reflect a button held
  // through reset; until then on_f is treated as already high so a held
  // button must be released and pressed again before it can arm.
  assign settled_c = (settle_q == SETTLE_W'(SETTLE_TICKS));
  assign settle_d  = (tick_c && !settled_c) ? settle_q + SETTLE_W'(1) : settle_q;
  assign on_prev_d = on_f | ~settled_c;
  assign on_rise_c = on_f & ~on_prev_q;

  // Next-state, hold counter and registered outputs.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    pulse_d = 1'b0;
    unique case (state_q)
      PWR_OFF: begin
        if (on_rise_c && !off_f) begin
          state_d = PWR_ARMING;
          hold_d  = '0;
        end
      end
      PWR_ARMING: begin
        if (!on_f || off_f) begin
          state_d = PWR_OFF;
          hold_d  = '0;
        end else if (tick_c) begin
          if (hold_q == HOLD_W'(ON_HOLD_TICKS - 1)) begin
            state_d = PWR_ON;
            pulse_d = 1'b1;
          end
          if (hold_q != HOLD_W'(ON_HOLD_TICKS)) begin
            hold_d = hold_q + HOLD_W'(1);
          end
        end
      end
      PWR_ON: begin
        if (off_f) begin
          state_d = PWR_OFF;
        end
      end
      default: begin
        state_d = PWR_OFF;
        hold_d  = '0;
      end
    endcase

    led_d  = (state_d == PWR_ON);
    mode_d = '0;
    if ((state_d == PWR_ON) && onehot_ok(MAX_MODES'(mode_f))) begin
      mode_d = mode_f;
    end
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt_q <= '0;
      settle_q   <= '0;
      on_prev_q  <= 1'b1;
      state_q    <= PWR_OFF;
      hold_q     <= '0;
      pulse_q    <= 1'b0;
      led_q      <= 1'b0;
      mode_q     <= '0;
    end else begin
      tick_cnt_q <= tick_cnt_d;
      settle_q   <= settle_d;
      on_prev_q  <= on_prev_d;
      state_q    <= state_d;
      hold_q     <= hold_d;
      pulse_q    <= pulse_d;
      led_q      <= led_d;
      mode_q     <= mode_d;
    end
  end

  assign power_led      = led_q;
  assign power_up_pulse = pulse_q;
  assign mode_en        = mode_q;
  assign mode_led       = mode_q;
  assign state          = state_q;

endmodule
